// File: rtl/spy_ctrl_pkg.sv
// Shared definitions for the spy buffer freeze controller: FSM state
// encoding (software reads it over VME, so values are fixed), the default
// buffer reset length, and helpers for slicing the concatenated
// per-buffer address bus.
package spy_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RESET_BUF = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ARMED     = 3'd2,
    ST_POST      = 3'd3,
    ST_FROZEN    = 3'd4
  } state_e;

  localparam int RST_CYCLES_DEFAULT = 4;

  // LSB of buffer idx inside a concatenated N_SPY*aw bus.
  function automatic int spy_lsb(input int idx, input int aw);
    return idx * aw;
  endfunction

  // Width of the buffer-select field; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spy_freeze_ctrl_if.sv
// Bundle between the VME register block / spy buffers and the freeze
// controller.
//   master : VME side and buffers; drives commands, trigger, push,
//            config and buffer status; receives control and status.
//   slave  : the controller itself.
interface spy_freeze_ctrl_if #(
  parameter int N_SPY = 4,
  parameter int AW    = 10
);
  import spy_ctrl_pkg::*;

  localparam int SEL_W = sel_width(N_SPY);

  logic                  cmd_arm;
  logic                  cmd_freeze;
  logic                  cmd_release;
  logic                  trig_in;
  logic                  push;
  logic [AW-1:0]         post_count;
  logic [SEL_W-1:0]      spy_sel;
  logic [N_SPY*AW-1:0]   spy_addr;
  logic [N_SPY-1:0]      spy_of;

  logic                  freeze;
  logic [N_SPY-1:0]      ispy_addr_sel;
  logic                  reset_ispy_data;
  logic [N_SPY*AW-1:0]   frozen_addr;
  logic [N_SPY-1:0]      of_sticky;
  logic [2:0]            state;

  modport master (
    output cmd_arm, cmd_freeze, cmd_release, trig_in, push,
           post_count, spy_sel, spy_addr, spy_of,
    input  freeze, ispy_addr_sel, reset_ispy_data, frozen_addr,
           of_sticky, state
  );

  modport slave (
    input  cmd_arm, cmd_freeze, cmd_release, trig_in, push,
           post_count, spy_sel, spy_addr, spy_of,
    output freeze, ispy_addr_sel, reset_ispy_data, frozen_addr,
           of_sticky, state
  );

endinterface

// File: rtl/spy_post_counter.sv
// Loadable down-counter for the post-trigger push count.
//   load/load_val : (re)start the count
//   dec           : count one push; saturates at zero
//   is_one        : the next counted push is the last one
module spy_post_counter #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          dec,
  output logic          is_one
);

  logic [AW-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: default first so every path assigns cnt_d; otherwise a latch is inferred.
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - AW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: non-blocking in clocked blocks so all flops update from pre-edge values.
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign is_one = (cnt_q == AW'(1));

endmodule

// File: rtl/spy_freeze_ctrl.sv
// Sequencing controller for N_SPY spy buffers sharing one push strobe and
// one VME readout path: buffer reset phase, arm/trigger/post-trigger
// freeze, write-pointer snapshot at freeze, then one-hot address select
// for readout of one buffer at a time.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : spy_freeze_ctrl_if slave (commands, trigger, push,
//                  config and buffer status in; freeze, address select,
//                  buffer reset, captured pointers, sticky overflow and
//                  FSM state out). All outputs are registered.
module spy_freeze_ctrl
  import spy_ctrl_pkg::*;
#(
  parameter int N_SPY      = 4,
  parameter int AW         = 10,
  parameter int RST_CYCLES = RST_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset_n,
  spy_freeze_ctrl_if.slave bus
);

  localparam int SEL_W = sel_width(N_SPY);
  localparam int RC_W  = $clog2(RST_CYCLES + 1);
  localparam logic [RC_W-1:0] RC_LOAD = RC_W'(RST_CYCLES);

  state_e               state_q, state_d;
  logic [RC_W-1:0]      rst_cnt_q, rst_cnt_d;
  logic                 cnt_load, cnt_dec, cnt_is_one;

  logic                 freeze_q, freeze_d;
  logic                 freeze_dly_q;
  logic                 rst_buf_q, rst_buf_d;
  logic [N_SPY-1:0]     sel_q, sel_d;
  logic [N_SPY-1:0]     of_q, of_d;
  logic [N_SPY*AW-1:0]  frozen_addr_q;

  spy_post_counter #(.AW(AW)) u_post_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (bus.post_count),
    .dec      (cnt_dec),
    .is_one   (cnt_is_one)
  );

  // State register plus the buffer-reset cycle counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RESET_BUF;
      rst_cnt_q <= RC_LOAD;
    end else begin
      state_q   <= state_d;
      rst_cnt_q <= rst_cnt_d;
    end
  end

  // Next state. Release beats freeze beats trigger beats arm.
  always_comb begin
    state_d   = state_q;
    rst_cnt_d = rst_cnt_q;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    if (bus.cmd_release) begin
      state_d   = ST_RESET_BUF;
      rst_cnt_d = RC_LOAD;
    end else begin
      case (state_q)
        ST_RESET_BUF: begin
          if (rst_cnt_q <= RC_W'(1)) state_d = ST_IDLE;
          else                       rst_cnt_d = rst_cnt_q - RC_W'(1);
        end
        ST_IDLE: begin
          if (bus.cmd_freeze)   state_d = ST_FROZEN;
          else if (bus.cmd_arm) state_d = ST_ARMED;
        end
        ST_ARMED: begin
          if (bus.cmd_freeze) begin
            state_d = ST_FROZEN;
          end else if (bus.trig_in) begin
            // A zero post count means the trigger point is the freeze point.
            if (bus.post_count == '0) begin
              state_d = ST_FROZEN;
            end else begin
              state_d  = ST_POST;
              cnt_load = 1'b1;
            end
          end
        end
        ST_POST: begin
          if (bus.cmd_freeze) begin
            state_d = ST_FROZEN;
          end else if (bus.push) begin
            cnt_dec = 1'b1;
            if (cnt_is_one) state_d = ST_FROZEN;
          end
        end
        ST_FROZEN: ;
        default: begin
          state_d   = ST_RESET_BUF;
          rst_cnt_d = RC_LOAD;
        end
      endcase
    end
  end

  // Output next values, decoded from the next state so the registered
  // outputs line up with the state they belong to.
  always_comb begin
    freeze_d  = (state_d == ST_FROZEN);
    rst_buf_d = (state_d == ST_RESET_BUF);
    sel_d     = '0;
    // Select only once the pointer snapshot has been taken (second frozen
    // cycle on). Out-of-range spy_sel matches no bit and leaves all zero.
    if ((state_q == ST_FROZEN) && (state_d == ST_FROZEN)) begin
      for (int i = 0; i < N_SPY; i++) begin
        sel_d[i] = (bus.spy_sel == SEL_W'(i));
      end
    end
    of_d = rst_buf_d ? '0 : (of_q | bus.spy_of);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      freeze_q      <= 1'b0;
      freeze_dly_q  <= 1'b0;
      rst_buf_q     <= 1'b1;
      sel_q         <= '0;
      of_q          <= '0;
      // NOTE: frozen_addr is a register bank read over VME, not a RAM, so it is reset too.
      frozen_addr_q <= '0;
    end else begin
      freeze_q     <= freeze_d;
      freeze_dly_q <= freeze_q;
      rst_buf_q    <= rst_buf_d;
      sel_q        <= sel_d;
      of_q         <= of_d;
      // First frozen cycle: the final pre-freeze push has landed and the
      // buffers' pointers are stable.
      if (freeze_q && !freeze_dly_q) begin
        for (int i = 0; i < N_SPY; i++) begin
          frozen_addr_q[spy_lsb(i, AW) +: AW] <= bus.spy_addr[spy_lsb(i, AW) +: AW];
        end
      end
    end
  end

  assign bus.freeze          = freeze_q;
  assign bus.reset_ispy_data = rst_buf_q;
  assign bus.ispy_addr_sel   = sel_q;
  assign bus.of_sticky       = of_q;
  assign bus.frozen_addr     = frozen_addr_q;
  assign bus.state           = state_q;

endmodule
